// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and default sizing for the serial chunk adder.
package serial_chunk_adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Chunk counter width: ceil(log2(n)), but never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk_adder.sv
// Combinational ripple-carry adder for one chunk, built from full_adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // Each cell owns its own carry nets so the chain is not one self-dependent vector.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_first
            assign c_in = ci;
        end else begin : g_next
            assign c_in = g_bit[i-1].c_out;
        end

        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c_in),
            .s  (s[i]),
            .co (c_out)
        );
    end

    assign co    = g_bit[CHUNK-1].c_out;
    assign c_msb = g_bit[CHUNK-1].c_in;

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock, LSB chunk first, with a
// one-cycle done pulse and registered sum/cout/ovf.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_msb;
    logic [WIDTH-1:0] res_next;
    logic             accept;

    assign accept = start && (state != ST_BUSY);

    always_comb begin
        x = a_reg[CHUNK*cnt +: CHUNK];
        y = b_reg[CHUNK*cnt +: CHUNK];
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x     (x),
        .y     (y),
        .ci    (carry),
        .s     (s),
        .co    (co),
        .c_msb (c_msb)
    );

    // Partial result holds the chunks already produced; the newest chunk enters
    // at the top so after NCHUNK steps chunk 0 sits at the bottom.
    if (NCHUNK > 1) begin : g_part
        logic [WIDTH-CHUNK-1:0] part;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                part <= '0;
            end else if (state == ST_BUSY) begin
                part <= res_next[WIDTH-1:CHUNK];
            end else if (accept) begin
                part <= '0;
            end
        end

        assign res_next = {s, part};
    end else begin : g_whole
        assign res_next = s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    carry <= co;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        sum   <= res_next;
                        cout  <= co;
                        ovf   <= co ^ c_msb;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to add a, b, cin; sampled only when accepted.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse; result outputs valid from this cycle.
REQ-011 sum  output  WIDTH  registered result a+b+cin modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 NCHUNK = WIDTH/CHUNK; states IDLE, BUSY, DONE.
REQ-015 IDLE: start=1 at an edge latches a, b, cin, clears chunk counter and carry register to cin, goes BUSY; start=0 stays IDLE.
REQ-016 BUSY: each edge adds chunk index cnt (LSB chunk first) of latched operands plus carry register, stores CHUNK sum bits into internal result shift register, updates carry register, increments cnt.
REQ-017 BUSY -> DONE on the edge processing chunk NCHUNK-1; same edge loads sum, cout, ovf from final values.
REQ-018 Latency: start accepted at edge k -> done=1 during cycle after edge k+NCHUNK (exactly NCHUNK+1 edges, 5 at defaults).
REQ-019 busy=1 exactly in BUSY; done=1 exactly in DONE; never both.
REQ-020 DONE: lasts one cycle; start=1 accepted (back-to-back, -> BUSY, same latching as IDLE); else -> IDLE.
REQ-021 start while BUSY is ignored; latched operands and counter unaffected.
REQ-022 a, b, cin may change freely after acceptance; result depends only on values latched at acceptance.
REQ-023 sum, cout, ovf change only on the completion edge (REQ-017) and hold until next completion or reset.
REQ-024 Chunk counter width ceil(log2(NCHUNK)), min 1; never exceeds NCHUNK-1.

Reset
REQ-025 rst_n=0 at an edge: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter, carry and operand registers 0.
REQ-026 Reset mid-operation abandons the addition; no done pulse; result outputs 0.
REQ-027 Reset overrides start at the same edge; first start accepted is at the first edge with rst_n=1.

Structure
REQ-028 Shared package holds the state enum (IDLE, BUSY, DONE) and default WIDTH/CHUNK constants.
REQ-029 One sub-module chunk_adder (parameter CHUNK; inputs x, y, ci; outputs s, co, c_msb carry-into-MSB) instantiating CHUNK full_adder cells in ripple; combinational only.
REQ-030 FSM, counter and shift/result registers live in serial_chunk_adder; no latches.

Verification (WIDTH=16, CHUNK=4)
REQ-031 a=0x1234, b=0x1111, cin=0, start one cycle -> busy 4 cycles, done pulse 5th cycle after accept, sum=0x2345, cout=0, ovf=0.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 a=0x000F, b=0x0000, cin=1 -> sum=0x0010 (carry crosses chunk boundary), cout=0.
REQ-034 Accept 0x0001+0x0002, pulse start and change a/b to 0xFFFF while busy -> sum=0x0003, busy remains 4 cycles, one done pulse.
REQ-035 start high in DONE with a=0x8000, b=0x8000 -> immediate BUSY, second done 5 cycles later, sum=0x0000, cout=1, ovf=1.
REQ-036 rst_n=0 for one edge during 2nd BUSY cycle -> busy=0, no done, sum=0; next start 0x0100+0x0100 -> sum=0x0200.
